wb_master_arbiter: RTL and testbench

//  Two-master Wishbone B3 bus arbiter. Shares one slave-side bus between the ao68000 CPU (m0) and a

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_watchdog.sv | 39 +++
 rtl/wb_master_arbiter.sv | 166 ++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: constants and types shared by the Wishbone arbiter files.
//   - CTI cycle-type codes (classic, constant-address, incrementing, end-of-burst)
//   - BTE burst-type codes (linear, 4/8/16-beat wrap)
//   - Arbiter state encoding (IDLE, GNT0, GNT1)
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_watchdog.sv
// wb_watchdog: stall detector for the shared Wishbone bus.
//   clk   in  system clock
//   rst_n in  asynchronous reset, active-low
//   stb   in  slave-side strobe currently asserted
//   term  in  any slave termination (ACK, ERR or RTY) this cycle
//   fire  out one-cycle pulse on the TIMEOUT-th consecutive unterminated strobe cycle
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    input  logic term,
    output logic fire
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // A real termination in the final cycle wins, so the forced error is suppressed then.
    assign fire = stb & ~term & (count == LAST_COUNT);

    // Count unterminated strobe cycles; restart after a fire so a master that keeps
    // strobing gets another full window before the next forced error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!stb || term || fire) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: two-master round-robin Wishbone B3 arbiter.
//   CLK_I, reset_n                  clock and asynchronous active-low reset
//   mN_CYC/STB/WE/ADR/DAT/SEL/CTI/BTE_I  request side of master N (N = 0, 1)
//   mN_DAT_O                        slave read data, broadcast to both masters
//   mN_ACK/ERR/RTY_O                terminations, delivered only to the granted master
//   s_*_O                           slave-side bus, driven by the granted master, zero when idle
//   s_DAT_I, s_ACK/ERR/RTY_I        slave response
//   grant_o                         one-hot grant, 2'b00 when idle
//   timeout_o                       one-cycle pulse when the watchdog forces ERR
module wb_master_arbiter
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 8
) (
    input  logic        CLK_I,
    input  logic        reset_n,
    input  logic        m0_CYC_I,
    input  logic        m0_STB_I,
    input  logic        m0_WE_I,
    input  logic [29:0] m0_ADR_I,
    input  logic [31:0] m0_DAT_I,
    input  logic [3:0]  m0_SEL_I,
    input  logic [2:0]  m0_CTI_I,
    input  logic [1:0]  m0_BTE_I,
    output logic [31:0] m0_DAT_O,
    output logic        m0_ACK_O,
    output logic        m0_ERR_O,
    output logic        m0_RTY_O,
    input  logic        m1_CYC_I,
    input  logic        m1_STB_I,
    input  logic        m1_WE_I,
    input  logic [29:0] m1_ADR_I,
    input  logic [31:0] m1_DAT_I,
    input  logic [3:0]  m1_SEL_I,
    input  logic [2:0]  m1_CTI_I,
    input  logic [1:0]  m1_BTE_I,
    output logic [31:0] m1_DAT_O,
    output logic        m1_ACK_O,
    output logic        m1_ERR_O,
    output logic        m1_RTY_O,
    output logic        s_CYC_O,
    output logic        s_STB_O,
    output logic        s_WE_O,
    output logic [29:0] s_ADR_O,
    output logic [31:0] s_DAT_O,
    output logic [3:0]  s_SEL_O,
    output logic [2:0]  s_CTI_O,
    output logic [1:0]  s_BTE_O,
    input  logic [31:0] s_DAT_I,
    input  logic        s_ACK_I,
    input  logic        s_ERR_I,
    input  logic        s_RTY_I,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    arb_state_t state;
    logic       last;
    logic       term;
    logic       fire;

    // Grant FSM. Every grant passes through IDLE, so the grant decision is always made
    // with a fresh look at both requests. "last" remembers who was served most recently
    // so that the other master wins a tie.
    always_ff @(posedge CLK_I or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant_o <= 2'b00;
            last    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_CYC_I && (!m1_CYC_I || last)) begin
                        state   <= GNT0;
                        grant_o <= 2'b01;
                    end else if (m1_CYC_I && (!m0_CYC_I || !last)) begin
                        state   <= GNT1;
                        grant_o <= 2'b10;
                    end
                end
                GNT0: begin
                    if (!m0_CYC_I) begin
                        state   <= IDLE;
                        grant_o <= 2'b00;
                        last    <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!m1_CYC_I) begin
                        state   <= IDLE;
                        grant_o <= 2'b00;
                        last    <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= 2'b00;
                end
            endcase
        end
    end

    // Slave-side mux: the granted master drives the bus, nothing drives it while idle.
    always_comb begin
        s_CYC_O = 1'b0;
        s_STB_O = 1'b0;
        s_WE_O  = 1'b0;
        s_ADR_O = '0;
        s_DAT_O = '0;
        s_SEL_O = '0;
        s_CTI_O = '0;
        s_BTE_O = '0;
        case (state)
            GNT0: begin
                s_CYC_O = m0_CYC_I;
                s_STB_O = m0_STB_I;
                s_WE_O  = m0_WE_I;
                s_ADR_O = m0_ADR_I;
                s_DAT_O = m0_DAT_I;
                s_SEL_O = m0_SEL_I;
                s_CTI_O = m0_CTI_I;
                s_BTE_O = m0_BTE_I;
            end
            GNT1: begin
                s_CYC_O = m1_CYC_I;
                s_STB_O = m1_STB_I;
                s_WE_O  = m1_WE_I;
                s_ADR_O = m1_ADR_I;
                s_DAT_O = m1_DAT_I;
                s_SEL_O = m1_SEL_I;
                s_CTI_O = m1_CTI_I;
                s_BTE_O = m1_BTE_I;
            end
            default: ;
        endcase
    end

    assign term = s_ACK_I | s_ERR_I | s_RTY_I;

    wb_watchdog #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) u_watchdog (
        .clk  (CLK_I),
        .rst_n(reset_n),
        .stb  (s_STB_O),
        .term (term),
        .fire (fire)
    );

    assign timeout_o = fire;

    assign m0_DAT_O = s_DAT_I;
    assign m1_DAT_O = s_DAT_I;

    // The watchdog error is merged into ERR so the stalled master sees an ordinary
    // bus error; the grant itself is untouched.
    assign m0_ACK_O = (state == GNT0) & s_ACK_I;
    assign m0_ERR_O = (state == GNT0) & (s_ERR_I | fire);
    assign m0_RTY_O = (state == GNT0) & s_RTY_I;
    assign m1_ACK_O = (state == GNT1) & s_ACK_I;
    assign m1_ERR_O = (state == GNT1) & (s_ERR_I | fire);
    assign m1_RTY_O = (state == GNT1) & s_RTY_I;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: self-checking bench for wb_master_arbiter (TIMEOUT = 16).
// Per-cycle expected control vectors are queued when stimulus is applied and popped
// at the following falling edge. Vector layout (MSB first):
//   grant[1:0], s_CYC, s_STB, m0_ACK, m1_ACK, m0_ERR, m1_ERR, timeout
module tb_wb_master_arbiter;

    logic        CLK_I;
    logic        reset_n;
    logic        m0_CYC_I, m0_STB_I, m0_WE_I;
    logic [29:0] m0_ADR_I;
    logic [31:0] m0_DAT_I;
    logic [3:0]  m0_SEL_I;
    logic [2:0]  m0_CTI_I;
    logic [1:0]  m0_BTE_I;
    logic [31:0] m0_DAT_O;
    logic        m0_ACK_O, m0_ERR_O, m0_RTY_O;
    logic        m1_CYC_I, m1_STB_I, m1_WE_I;
    logic [29:0] m1_ADR_I;
    logic [31:0] m1_DAT_I;
    logic [3:0]  m1_SEL_I;
    logic [2:0]  m1_CTI_I;
    logic [1:0]  m1_BTE_I;
    logic [31:0] m1_DAT_O;
    logic        m1_ACK_O, m1_ERR_O, m1_RTY_O;
    logic        s_CYC_O, s_STB_O, s_WE_O;
    logic [29:0] s_ADR_O;
    logic [31:0] s_DAT_O;
    logic [3:0]  s_SEL_O;
    logic [2:0]  s_CTI_O;
    logic [1:0]  s_BTE_O;
    logic [31:0] s_DAT_I;
    logic        s_ACK_I, s_ERR_I, s_RTY_I;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] sb[$];

    wb_master_arbiter #(
        .TIMEOUT(16),
        .CNT_W  (4)
    ) dut (
        .CLK_I(CLK_I), .reset_n(reset_n),
        .m0_CYC_I(m0_CYC_I), .m0_STB_I(m0_STB_I), .m0_WE_I(m0_WE_I), .m0_ADR_I(m0_ADR_I),
        .m0_DAT_I(m0_DAT_I), .m0_SEL_I(m0_SEL_I), .m0_CTI_I(m0_CTI_I), .m0_BTE_I(m0_BTE_I),
        .m0_DAT_O(m0_DAT_O), .m0_ACK_O(m0_ACK_O), .m0_ERR_O(m0_ERR_O), .m0_RTY_O(m0_RTY_O),
        .m1_CYC_I(m1_CYC_I), .m1_STB_I(m1_STB_I), .m1_WE_I(m1_WE_I), .m1_ADR_I(m1_ADR_I),
        .m1_DAT_I(m1_DAT_I), .m1_SEL_I(m1_SEL_I), .m1_CTI_I(m1_CTI_I), .m1_BTE_I(m1_BTE_I),
        .m1_DAT_O(m1_DAT_O), .m1_ACK_O(m1_ACK_O), .m1_ERR_O(m1_ERR_O), .m1_RTY_O(m1_RTY_O),
        .s_CYC_O(s_CYC_O), .s_STB_O(s_STB_O), .s_WE_O(s_WE_O), .s_ADR_O(s_ADR_O),
        .s_DAT_O(s_DAT_O), .s_SEL_O(s_SEL_O), .s_CTI_O(s_CTI_O), .s_BTE_O(s_BTE_O),
        .s_DAT_I(s_DAT_I), .s_ACK_I(s_ACK_I), .s_ERR_I(s_ERR_I), .s_RTY_I(s_RTY_I),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    // 10-unit clock; inputs change 1 unit after the rising edge, outputs are sampled
    // on the falling edge.
    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    // Hard stop in case a test sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1, "[TB] time limit");
    end

    function automatic logic [8:0] observe();
        return {grant_o, s_CYC_O, s_STB_O, m0_ACK_O, m1_ACK_O, m0_ERR_O, m1_ERR_O, timeout_o};
    endfunction

    // Drive one cycle of handshake stimulus and queue the outputs it should produce.
    // ctl = {m0_CYC, m0_STB, m1_CYC, m1_STB}, term = {ACK, ERR, RTY}
    task automatic apply_stimulus(input logic [3:0] ctl, input logic [2:0] term, input logic [8:0] exp);
        @(posedge CLK_I);
        #1;
        {m0_CYC_I, m0_STB_I, m1_CYC_I, m1_STB_I} = ctl;
        {s_ACK_I, s_ERR_I, s_RTY_I} = term;
        sb.push_back(exp);
    endtask

    // Put every input into a quiet state and pulse reset.
    task automatic do_reset();
        reset_n = 1'b0;
        {m0_CYC_I, m0_STB_I, m0_WE_I, m1_CYC_I, m1_STB_I, m1_WE_I} = '0;
        m0_ADR_I = '0; m0_DAT_I = '0; m0_SEL_I = '0; m0_CTI_I = '0; m0_BTE_I = '0;
        m1_ADR_I = '0; m1_DAT_I = '0; m1_SEL_I = '0; m1_CTI_I = '0; m1_BTE_I = '0;
        s_DAT_I = '0;
        {s_ACK_I, s_ERR_I, s_RTY_I} = '0;
        repeat (2) @(posedge CLK_I);
        #1 reset_n = 1'b1;
    endtask

    // While reset is held everything on the slave side and every termination is 0,
    // no matter what the masters and the slave are doing.
    task automatic test_reset();
        logic [8:0] e, o;
        do_reset();
        reset_n = 1'b0;
        {m0_CYC_I, m0_STB_I, m1_CYC_I, m1_STB_I} = 4'b1111;
        {s_ACK_I, s_ERR_I, s_RTY_I} = 3'b111;
        m0_ADR_I = 30'h3FF_FFFF; m0_DAT_I = 32'hFFFF_FFFF; m0_SEL_I = 4'hF; m0_WE_I = 1'b1;
        s_DAT_I  = 32'hA5A5_0F0F;
        sb.push_back(9'b00_0_0_0_0_0_0_0);
        repeat (3) @(posedge CLK_I);
        @(negedge CLK_I);
        e = sb.pop_front();
        o = observe();
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctl: got %b, expected %b", o, e);
        end
        tests_run++;
        if ({s_WE_O, s_ADR_O, s_DAT_O, s_SEL_O, s_CTI_O, s_BTE_O} !== 72'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bus: got adr %h dat %h sel %h, expected all zero", s_ADR_O, s_DAT_O, s_SEL_O);
        end
        tests_run++;
        if ({m0_DAT_O, m1_DAT_O} !== {32'hA5A5_0F0F, 32'hA5A5_0F0F}) begin
            tests_failed++;
            $display("[TB] FAIL reset_dat_broadcast: got %h/%h, expected a5a50f0f", m0_DAT_O, m1_DAT_O);
        end
    endtask

    // Reset asserted while m1 owns the bus drops the grant at once; afterwards a tie goes to m0.
    task automatic test_reset_mid_grant();
        logic [8:0] e, o;
        logic [8:0] want [0:1];
        want = '{9'b00_0_0_0_0_0_0_0, 9'b10_1_0_0_0_0_0_0};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(4'b0010, 3'b000, want[i]);
            @(negedge CLK_I);
            e = sb.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL mid_grant_setup[%0d]: got %b, expected %b", i, o, e);
            end
        end
        #1;
        m0_CYC_I = 1'b1;
        sb.push_back(9'b00_0_0_0_0_0_0_0);
        reset_n = 1'b0;
        #1;
        e = sb.pop_front();
        o = observe();
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got %b, expected %b", o, e);
        end
        @(posedge CLK_I);
        #1 reset_n = 1'b1;
        apply_stimulus(4'b1010, 3'b000, 9'b01_1_0_0_0_0_0_0);
        @(negedge CLK_I);
        e = sb.pop_front();
        o = observe();
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("[TB] FAIL first_after_reset: got %b, expected %b", o, e);
        end
    endtask

    // Simultaneous requests alternate between the masters with one idle cycle between grants.
    task automatic test_contention();
        logic [8:0] e, o;
        logic [3:0] ctl  [0:9];
        logic [8:0] want [0:9];
        ctl  = '{4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b0010,
                 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        want = '{9'b00_0_0_0_0_0_0_0, 9'b01_1_0_0_0_0_0_0, 9'b01_0_0_0_0_0_0_0,
                 9'b00_0_0_0_0_0_0_0, 9'b10_1_0_0_0_0_0_0, 9'b10_0_0_0_0_0_0_0,
                 9'b00_0_0_0_0_0_0_0, 9'b01_1_0_0_0_0_0_0, 9'b01_0_0_0_0_0_0_0,
                 9'b00_0_0_0_0_0_0_0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(ctl[i], 3'b000, want[i]);
            @(negedge CLK_I);
            e = sb.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL contention[%0d]: got %b, expected %b", i, o, e);
            end
        end
    endtask

    // A four-beat incrementing burst from m0 is not interrupted by a waiting m1.
    task automatic test_burst_hold();
        logic [8:0] e, o;
        logic [3:0] ctl  [0:7];
        logic [2:0] term [0:7];
        logic [2:0] cti  [0:7];
        logic [8:0] want [0:7];
        ctl  = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b0010, 4'b0010, 4'b0010};
        term = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
        cti  = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b111, 3'b000, 3'b000, 3'b000};
        want = '{9'b00_0_0_0_0_0_0_0, 9'b01_1_1_1_0_0_0_0, 9'b01_1_1_1_0_0_0_0,
                 9'b01_1_1_1_0_0_0_0, 9'b01_1_1_1_0_0_0_0, 9'b01_0_0_0_0_0_0_0,
                 9'b00_0_0_0_0_0_0_0, 9'b10_1_0_0_0_0_0_0};
        do_reset();
        m0_BTE_I = 2'b00;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(ctl[i], term[i], want[i]);
            m0_CTI_I = cti[i];
            @(negedge CLK_I);
            e = sb.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL burst[%0d]: got %b, expected %b", i, o, e);
            end
            if (i >= 1 && i <= 4) begin
                tests_run++;
                if (s_CTI_O !== cti[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL burst_cti[%0d]: got %b, expected %b", i, s_CTI_O, cti[i]);
                end
            end
        end
    endtask

    // m1 strobes into a silent slave: the 16th strobe cycle gets a forced ERR, the grant stays.
    task automatic test_timeout();
        logic [8:0] e, o, exp;
        logic       hit;
        do_reset();
        m1_ADR_I = 30'h2AA_AAAA; m1_WE_I = 1'b1; m1_DAT_I = 32'h0BAD_F00D; m1_SEL_I = 4'h3;
        for (int i = 0; i < 20; i++) begin
            hit = (i == 16);
            if (i == 0 || i == 19)
                exp = 9'b00_0_0_0_0_0_0_0;
            else if (i == 18)
                exp = 9'b10_0_0_0_0_0_0_0;
            else
                exp = {7'b10_1_1_0_0_0, hit, hit};
            apply_stimulus((i < 18) ? 4'b0011 : 4'b0000, 3'b000, exp);
            @(negedge CLK_I);
            e = sb.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL timeout[%0d]: got %b, expected %b", i, o, e);
            end
            if (i == 1) begin
                tests_run++;
                if ({s_ADR_O, s_DAT_O, s_SEL_O, s_WE_O} !== {30'h2AA_AAAA, 32'h0BAD_F00D, 4'h3, 1'b1}) begin
                    tests_failed++;
                    $display("[TB] FAIL m1_mux: got adr %h dat %h sel %h we %b, expected 2aaaaaa 0badf00d 3 1",
                             s_ADR_O, s_DAT_O, s_SEL_O, s_WE_O);
                end
            end
        end
    endtask

    // m0 single read: slave data and ACK reach m0 in the same cycle.
    task automatic test_read_path();
        logic [8:0] e, o;
        do_reset();
        m0_ADR_I = 30'h0000_0100; m0_WE_I = 1'b0; m0_SEL_I = 4'hF; m0_DAT_I = 32'h1234_5678;
        m0_CTI_I = 3'b000; m0_BTE_I = 2'b01;
        m1_ADR_I = 30'h1555_5555;

        apply_stimulus(4'b1100, 3'b000, 9'b00_0_0_0_0_0_0_0);
        @(negedge CLK_I);
        e = sb.pop_front();
        o = observe();
        tests_run++;
        if (o !== e || s_ADR_O !== 30'd0) begin
            tests_failed++;
            $display("[TB] FAIL read_idle: got %b adr %h, expected %b adr 0", o, s_ADR_O, e);
        end

        apply_stimulus(4'b1100, 3'b100, 9'b01_1_1_1_0_0_0_0);
        s_DAT_I = 32'hDEAD_BEEF;
        @(negedge CLK_I);
        e = sb.pop_front();
        o = observe();
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("[TB] FAIL read_ctl: got %b, expected %b", o, e);
        end
        tests_run++;
        if (m0_DAT_O !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("[TB] FAIL read_data: got %h, expected deadbeef", m0_DAT_O);
        end
        tests_run++;
        if ({s_ADR_O, s_WE_O, s_SEL_O, s_DAT_O, s_BTE_O} !== {30'h0000_0100, 1'b0, 4'hF, 32'h1234_5678, 2'b01}) begin
            tests_failed++;
            $display("[TB] FAIL read_mux: got adr %h we %b sel %h dat %h bte %b, expected 100 0 f 12345678 01",
                     s_ADR_O, s_WE_O, s_SEL_O, s_DAT_O, s_BTE_O);
        end

        apply_stimulus(4'b0000, 3'b000, 9'b01_0_0_0_0_0_0_0);
        @(negedge CLK_I);
        e = sb.pop_front();
        o = observe();
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("[TB] FAIL read_release: got %b, expected %b", o, e);
        end
    endtask

    // Slave ACK in the cycle the watchdog would fire: ACK wins, and the counter starts
    // over, so the next forced error comes a full 16 strobe cycles later.
    task automatic test_race();
        logic [8:0] e, o, exp;
        logic       ack, err;
        do_reset();
        for (int i = 0; i < 35; i++) begin
            ack = (i == 16);
            err = (i == 32);
            if (i == 0 || i == 34)
                exp = 9'b00_0_0_0_0_0_0_0;
            else if (i == 33)
                exp = 9'b01_0_0_0_0_0_0_0;
            else
                exp = {2'b01, 1'b1, 1'b1, ack, 1'b0, err, 1'b0, err};
            apply_stimulus((i <= 32) ? 4'b1100 : 4'b0000, {ack, 2'b00}, exp);
            @(negedge CLK_I);
            e = sb.pop_front();
            o = observe();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL race[%0d]: got %b, expected %b", i, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_grant();
        test_contention();
        test_burst_hold();
        test_timeout();
        test_read_path();
        test_race();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
